// File: rtl/ps2_keymatrix_pkg.sv
// Shared types, scan code constants and the set-2 to TI-99/2 key table.
package ps2_keymatrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_t;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_AA = 8'hAA;
  localparam logic [7:0] BYTE_00 = 8'h00;
  localparam logic [7:0] BYTE_FF = 8'hFF;

  // Pause (E1) sequence: bytes swallowed after the E1 prefix.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // {ext, scan code} -> {hit, row, col}; col is always 0..5.
  function automatic logic [6:0] key_lookup(input logic [8:0] key);
    logic [6:0] res;
    res = 7'd0;
    case (key)
      9'h016: res = {1'b1, 3'd0, 3'd0};  // 1
      9'h01E: res = {1'b1, 3'd0, 3'd1};  // 2
      9'h026: res = {1'b1, 3'd0, 3'd2};  // 3
      9'h025: res = {1'b1, 3'd0, 3'd3};  // 4
      9'h02E: res = {1'b1, 3'd0, 3'd4};  // 5
      9'h029: res = {1'b1, 3'd0, 3'd5};  // space
      9'h015: res = {1'b1, 3'd1, 3'd0};  // Q
      9'h01D: res = {1'b1, 3'd1, 3'd1};  // W
      9'h024: res = {1'b1, 3'd1, 3'd2};  // E
      9'h02D: res = {1'b1, 3'd1, 3'd3};  // R
      9'h02C: res = {1'b1, 3'd1, 3'd4};  // T
      9'h035: res = {1'b1, 3'd1, 3'd5};  // Y
      9'h00D: res = {1'b1, 3'd2, 3'd0};  // tab
      9'h01C: res = {1'b1, 3'd2, 3'd1};  // A
      9'h01B: res = {1'b1, 3'd2, 3'd2};  // S
      9'h023: res = {1'b1, 3'd2, 3'd3};  // D
      9'h02B: res = {1'b1, 3'd2, 3'd4};  // F
      9'h034: res = {1'b1, 3'd2, 3'd5};  // G
      9'h01A: res = {1'b1, 3'd3, 3'd0};  // Z
      9'h022: res = {1'b1, 3'd3, 3'd1};  // X
      9'h021: res = {1'b1, 3'd3, 3'd2};  // C
      9'h02A: res = {1'b1, 3'd3, 3'd3};  // V
      9'h032: res = {1'b1, 3'd3, 3'd4};  // B
      9'h031: res = {1'b1, 3'd3, 3'd5};  // N
      9'h036: res = {1'b1, 3'd4, 3'd0};  // 6
      9'h03D: res = {1'b1, 3'd4, 3'd1};  // 7
      9'h03E: res = {1'b1, 3'd4, 3'd2};  // 8
      9'h175: res = {1'b1, 3'd4, 3'd3};  // up
      9'h172: res = {1'b1, 3'd4, 3'd4};  // down
      9'h16B: res = {1'b1, 3'd4, 3'd5};  // left
      9'h174: res = {1'b1, 3'd5, 3'd0};  // right
      9'h03C: res = {1'b1, 3'd5, 3'd1};  // U
      9'h043: res = {1'b1, 3'd5, 3'd2};  // I
      9'h044: res = {1'b1, 3'd5, 3'd3};  // O
      9'h04D: res = {1'b1, 3'd5, 3'd4};  // P
      9'h03B: res = {1'b1, 3'd5, 3'd5};  // J
      9'h042: res = {1'b1, 3'd6, 3'd0};  // K
      9'h04B: res = {1'b1, 3'd6, 3'd1};  // L
      9'h03A: res = {1'b1, 3'd6, 3'd2};  // M
      9'h041: res = {1'b1, 3'd6, 3'd3};  // comma
      9'h049: res = {1'b1, 3'd6, 3'd4};  // period
      9'h012: res = {1'b1, 3'd6, 3'd5};  // left shift
      9'h05A: res = {1'b1, 3'd7, 3'd0};  // enter
      9'h046: res = {1'b1, 3'd7, 3'd1};  // 9
      9'h045: res = {1'b1, 3'd7, 3'd2};  // 0
      9'h014: res = {1'b1, 3'd7, 3'd3};  // left ctrl
      9'h011: res = {1'b1, 3'd7, 3'd4};  // left alt
      9'h076: res = {1'b1, 3'd7, 3'd5};  // esc
      default: res = 7'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ps2_keymatrix_rx.sv
// PS/2 frame receiver: pin synchronizers, clock glitch filter, 11-bit frame, idle timeout.
module ps2_keymatrix_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          bit_evt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par;
  logic [TW-1:0] tmo_cnt;
  logic          data_s;

  assign data_s = data_sync[1];

  // Two-flop synchronizers; idle bus level is high.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Accept a new clock level only after FILTER_LEN consecutive differing samples; flag falling edges.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= FW'(FILTER_LEN - 1);
      bit_evt  <= 1'b0;
    end else begin
      bit_evt <= 1'b0;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= FW'(FILTER_LEN - 1);
      end else if (filt_cnt == '0) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= FW'(FILTER_LEN - 1);
        bit_evt  <= ~clk_sync[1];
      end else begin
        filt_cnt <= filt_cnt - 1'b1;
      end
    end
  end

  // Frame assembly: start, 8 data LSB first, odd parity, stop; partial frames expire on timeout.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      bit_cnt  <= 4'd0;
      shift    <= 8'h00;
      par      <= 1'b0;
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
      tmo_cnt  <= TW'(TIMEOUT);
    end else begin
      rx_valid <= 1'b0;
      if (bit_evt) begin
        tmo_cnt <= TW'(TIMEOUT);
        if (bit_cnt == 4'd0) begin
          if (!data_s) bit_cnt <= 4'd1;
        end else if (bit_cnt <= 4'd8) begin
          shift   <= {data_s, shift[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd9) begin
          par     <= data_s;
          bit_cnt <= 4'd10;
        end else begin
          bit_cnt <= 4'd0;
          if (data_s && (^{shift, par})) begin
            rx_byte  <= shift;
            rx_valid <= 1'b1;
          end
        end
      end else if (bit_cnt != 4'd0) begin
        if (tmo_cnt == '0) bit_cnt <= 4'd0;
        else               tmo_cnt <= tmo_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_keymatrix.sv
// PS/2 set-2 keyboard to TI-99/2 key matrix: decoder FSM, key state, CRU sense line.
//
// state      | meaning
// ST_IDLE    | waiting for a code or prefix
// ST_EXT     | E0 seen, next byte is an extended make or F0
// ST_BRK     | F0 seen, next byte is released
// ST_EXT_BRK | E0 F0 seen, next byte is an extended release
module ps2_keymatrix
  import ps2_keymatrix_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [5:0] col_n,
  input  logic [2:0] row,
  output logic       key_n,
  output logic       code_stb,
  output logic [7:0] code
);

  logic [7:0]       rx_byte;
  logic             rx_valid;
  dec_state_t       state, state_next;
  logic [2:0]       skip_cnt, skip_next;
  logic             do_set, do_clr, do_wipe, lk_ext;
  logic [6:0]       lk;
  logic [5:0]       col_mask;
  logic [7:0][5:0]  matrix;

  ps2_keymatrix_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) u_rx (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid)
  );

  assign code     = rx_byte;
  assign code_stb = rx_valid;
  assign lk       = key_lookup({lk_ext, rx_byte});
  assign col_mask = 6'b000001 << lk[2:0];
  assign key_n    = ~|(matrix[row] & ~col_n);

  // Decoder state and pause-swallow counter registers.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= 3'd0;
    end else begin
      state    <= state_next;
      skip_cnt <= skip_next;
    end
  end

  // Next state and matrix actions for each received byte.
  always_comb begin
    state_next = state;
    skip_next  = skip_cnt;
    do_set     = 1'b0;
    do_clr     = 1'b0;
    do_wipe    = 1'b0;
    lk_ext     = 1'b0;
    if (rx_valid) begin
      if (skip_cnt != 3'd0) begin
        skip_next = skip_cnt - 3'd1;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (rx_byte == BYTE_E0)      state_next = ST_EXT;
            else if (rx_byte == BYTE_F0) state_next = ST_BRK;
            else if (rx_byte == BYTE_E1) skip_next  = PAUSE_SKIP;
            else if (rx_byte == BYTE_00 || rx_byte == BYTE_FF || rx_byte == BYTE_AA) do_wipe = 1'b1;
            else                         do_set     = 1'b1;
          end
          ST_EXT: begin
            lk_ext = 1'b1;
            if (rx_byte == BYTE_F0) begin
              state_next = ST_EXT_BRK;
            end else begin
              do_set     = 1'b1;
              state_next = ST_IDLE;
            end
          end
          ST_BRK: begin
            do_clr     = 1'b1;
            state_next = ST_IDLE;
          end
          ST_EXT_BRK: begin
            lk_ext     = 1'b1;
            do_clr     = 1'b1;
            state_next = ST_IDLE;
          end
          default: state_next = ST_IDLE;
        endcase
      end
    end
  end

  // Key-down state; lookup misses leave the matrix alone.
  always_ff @(posedge clk_25mhz) begin
    if (reset || do_wipe) begin
      matrix <= '0;
    end else if (lk[6]) begin
      if (do_set)      matrix[lk[5:3]] <= matrix[lk[5:3]] | col_mask;
      else if (do_clr) matrix[lk[5:3]] <= matrix[lk[5:3]] & ~col_mask;
    end
  end

endmodule
